// File: rtl/flash_field_gen.sv
// Flash-field and overlay pixel generator for the lag-measurement video path.
// Frame counter with rotating jitter drives the flash cycle; pixels leave through a fixed 2-stage pipeline.
module flash_field_gen #(
  parameter int                    NUM_FIELDS  = 3,
  parameter int                    PERIOD      = 30,
  parameter int                    ON_FRAMES   = 5,
  parameter int                    JITTER_BITS = 3,
  parameter int                    DATA_WIDTH  = 24,
  parameter logic [DATA_WIDTH-1:0] FIELD_COLOR = '1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     frame_start,
  input  logic                     de,
  input  logic [11:0]              pos_x,
  input  logic [11:0]              pos_y,
  input  logic [48*NUM_FIELDS-1:0] field_rects,
  input  logic                     overlay_valid,
  input  logic                     overlay_bit,
  output logic                     starttrigger,
  output logic                     display_on,
  output logic [2:0]               field_sel,
  output logic                     de_out,
  output logic [DATA_WIDTH-1:0]    data
);

  localparam int JW   = (JITTER_BITS > 0) ? JITTER_BITS : 1;
  localparam int JMAX = (JITTER_BITS > 0) ? ((1 << JITTER_BITS) - 1) : 0;
  localparam int CW   = $clog2(PERIOD + JMAX + 1);

  logic [CW-1:0]         frame_cnt_r, cnt_next_s, limit_s;
  logic [JW-1:0]         jitter_r, jit_next_s;
  logic [2:0]            burst_r, burst_next_s;
  logic [1:0]            mode_q_r, mode_next_s;
  logic                  first_r, first_next_s, disp_next_s, trig_next_s;

  logic [NUM_FIELDS-1:0] rect_hit_s, hit_r;
  logic                  disp1_r, ovl_valid_r, ovl_bit_r, de1_r;
  logic [1:0]            mode1_r;
  logic [2:0]            burst1_r;
  logic                  sel_hit_s, lit_s;
  logic [DATA_WIDTH-1:0] pix_s;

  assign limit_s = CW'(PERIOD - 1) + CW'(jitter_r);

  // Flash-cycle sequencing; every decision uses the pre-event counter values
  always_comb begin
    cnt_next_s   = frame_cnt_r;
    jit_next_s   = jitter_r;
    burst_next_s = burst_r;
    mode_next_s  = mode_q_r;
    first_next_s = first_r;
    disp_next_s  = display_on;
    trig_next_s  = 1'b0;
    if (frame_start) begin
      if (enable) begin
        cnt_next_s = (frame_cnt_r < limit_s) ? frame_cnt_r + CW'(1) : '0;
        jit_next_s = (JITTER_BITS > 0) ? jitter_r + JW'(1) : '0;
        if (frame_cnt_r == '0) begin
          trig_next_s  = 1'b1;
          disp_next_s  = 1'b1;
          mode_next_s  = mode;
          first_next_s = 1'b0;
          // the very first cycle after reset lights field 0
          if (first_r) begin
            burst_next_s = burst_r;
          end else begin
            burst_next_s = (burst_r == 3'(NUM_FIELDS - 1)) ? 3'd0 : burst_r + 3'd1;
          end
        end else if (frame_cnt_r > CW'(ON_FRAMES - 1)) begin
          disp_next_s = 1'b0;
        end else begin
          disp_next_s = display_on;
        end
      end else begin
        disp_next_s = 1'b0;
      end
    end else begin
      trig_next_s = 1'b0;
    end
  end

  // Frame/flash state registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_cnt_r  <= '0;
      jitter_r     <= '0;
      burst_r      <= 3'd0;
      mode_q_r     <= 2'd0;
      first_r      <= 1'b1;
      starttrigger <= 1'b0;
      display_on   <= 1'b0;
      field_sel    <= 3'd0;
    end else begin
      frame_cnt_r  <= cnt_next_s;
      jitter_r     <= jit_next_s;
      burst_r      <= burst_next_s;
      mode_q_r     <= mode_next_s;
      first_r      <= first_next_s;
      starttrigger <= trig_next_s;
      display_on   <= disp_next_s;
      field_sel    <= (mode_next_s == 2'd1) ? burst_next_s : 3'd0;
    end
  end

  // Half-open rectangle tests; a degenerate rectangle can never satisfy both bounds
  always_comb begin
    rect_hit_s = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      rect_hit_s[k] = (pos_x >= field_rects[48*k+36 +: 12]) && (pos_x < field_rects[48*k+24 +: 12]) &&
                      (pos_y >= field_rects[48*k+12 +: 12]) && (pos_y < field_rects[48*k +: 12]);
    end
  end

  // Stage 1: hit vector, flash state and overlay decision
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hit_r       <= '0;
      disp1_r     <= 1'b0;
      mode1_r     <= 2'd0;
      burst1_r    <= 3'd0;
      ovl_valid_r <= 1'b0;
      ovl_bit_r   <= 1'b0;
      de1_r       <= 1'b0;
    end else begin
      hit_r       <= rect_hit_s;
      disp1_r     <= display_on;
      mode1_r     <= mode_q_r;
      burst1_r    <= burst_r;
      ovl_valid_r <= overlay_valid;
      ovl_bit_r   <= overlay_bit;
      de1_r       <= de;
    end
  end

  // Pixel priority: lit field, then overlay, then black
  always_comb begin
    sel_hit_s = 1'b0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      sel_hit_s = sel_hit_s | ((burst1_r == 3'(k)) & hit_r[k]);
    end
    lit_s = 1'b0;
    case (mode1_r)
      2'd1:    lit_s = sel_hit_s;
      2'd2:    lit_s = 1'b1;
      default: lit_s = |hit_r;
    endcase
    pix_s = '0;
    if (!de1_r) begin
      pix_s = '0;
    end else if (disp1_r && lit_s) begin
      pix_s = FIELD_COLOR;
    end else if (ovl_valid_r) begin
      pix_s = ovl_bit_r ? FIELD_COLOR : '0;
    end else begin
      pix_s = '0;
    end
  end

  // Stage 2: output pixel and qualifier
  always_ff @(posedge clock) begin
    if (!resetn) begin
      data   <= '0;
      de_out <= 1'b0;
    end else begin
      data   <= pix_s;
      de_out <= de1_r;
    end
  end

endmodule

// File: tb/tb_flash_field_gen.sv
// Directed bench for flash_field_gen: flash timing with jitter, mode 0/1/2 pixels,
// overlay priority, enable hold and mid-stream reset.
module tb_flash_field_gen;

  localparam int NF = 3;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            enable = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            frame_start = 1'b0;
  logic            de = 1'b0;
  logic [11:0]     pos_x = 12'd0;
  logic [11:0]     pos_y = 12'd0;
  logic [48*NF-1:0] field_rects;
  logic            overlay_valid = 1'b0;
  logic            overlay_bit = 1'b0;
  logic            starttrigger, display_on, de_out;
  logic [2:0]      field_sel;
  logic [23:0]     data;

  int tests = 0;
  int fails = 0;

  logic [13:0] trig_exp;
  logic [13:0] disp_exp;
  int          sel_exp [4];

  always #5 clock = ~clock;

  flash_field_gen #(
    .NUM_FIELDS(NF), .PERIOD(4), .ON_FRAMES(2), .JITTER_BITS(2), .DATA_WIDTH(24), .FIELD_COLOR(24'hFFFFFF)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .mode(mode), .frame_start(frame_start),
    .de(de), .pos_x(pos_x), .pos_y(pos_y), .field_rects(field_rects),
    .overlay_valid(overlay_valid), .overlay_bit(overlay_bit),
    .starttrigger(starttrigger), .display_on(display_on), .field_sel(field_sel),
    .de_out(de_out), .data(data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int k, input int xs, input int xe, input int ys, input int ye);
    field_rects[48*k +: 48] = {12'(xs), 12'(xe), 12'(ys), 12'(ye)};
  endtask

  task automatic fevent();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One pixel in, checked 2 cycles later
  task automatic pix(input string tag, input int x, input int y, input logic ov_v, input logic ov_b,
                     input logic [23:0] exp);
    pos_x = 12'(x); pos_y = 12'(y); de = 1'b1; overlay_valid = ov_v; overlay_bit = ov_b;
    tick();
    de = 1'b0; overlay_valid = 1'b0; overlay_bit = 1'b0;
    tick();
    chk({tag, "_data"}, 32'(data), 32'(exp));
    chk({tag, "_de"}, 32'(de_out), 32'd1);
  endtask

  // 14 frame events from a fresh cycle; with do_sel, also check mode-1 field rotation
  task automatic run14(input logic do_sel);
    int idx;
    int k;
    idx = 0;
    for (int e = 0; e < 14; e++) begin
      fevent();
      chk($sformatf("trig_e%0d", e + 1), 32'(starttrigger), 32'(trig_exp[e]));
      chk($sformatf("disp_e%0d", e + 1), 32'(display_on), 32'(disp_exp[e]));
      if (do_sel && trig_exp[e]) begin
        k = sel_exp[idx];
        idx++;
        chk($sformatf("field_sel_e%0d", e + 1), 32'(field_sel), 32'(k));
        pix($sformatf("m1_lit_f%0d", k), 15 + 20*k, 6, 1'b0, 1'b0, 24'hFFFFFF);
        pix($sformatf("m1_unsel_f%0d", (k + 1) % 3), 15 + 20*((k + 1) % 3), 6, 1'b0, 1'b0, 24'h000000);
        pix($sformatf("m1_ovl1_f%0d", (k + 1) % 3), 15 + 20*((k + 1) % 3), 6, 1'b1, 1'b1, 24'hFFFFFF);
        pix($sformatf("m1_ovl0_f%0d", (k + 1) % 3), 15 + 20*((k + 1) % 3), 6, 1'b1, 1'b0, 24'h000000);
      end
      if (do_sel && e == 2) begin
        pix("dark_field", 15, 6, 1'b0, 1'b0, 24'h000000);
        pix("dark_ovl1", 15, 6, 1'b1, 1'b1, 24'hFFFFFF);
        pix("dark_ovl0", 15, 6, 1'b1, 1'b0, 24'h000000);
      end
      tick();
      chk($sformatf("trig_low_e%0d", e + 1), 32'(starttrigger), 32'd0);
    end
  endtask

  initial begin
    trig_exp = 14'b10001000100001;
    disp_exp = 14'b10011001100011;
    sel_exp  = '{0, 1, 2, 0};
    field_rects = '0;
    set_rect(0, 10, 20, 5, 8);
    set_rect(1, 30, 40, 5, 8);
    set_rect(2, 50, 60, 5, 8);

    // reset state
    tick();
    tick();
    chk("rst_trig", 32'(starttrigger), 32'd0);
    chk("rst_disp", 32'(display_on), 32'd0);
    chk("rst_sel", 32'(field_sel), 32'd0);
    chk("rst_de_out", 32'(de_out), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    resetn = 1'b1;
    enable = 1'b1;
    tick();

    // flash timing with jitter, mode 0
    run14(1'b0);

    // mode-0 pixels back to back: 2-cycle latency, de_out tracks de
    set_rect(2, 50, 50, 5, 8);
    pos_x = 12'd19; pos_y = 12'd7; de = 1'b1;
    tick();
    chk("pipe_lat_de", 32'(de_out), 32'd0);
    pos_x = 12'd20;
    tick();
    chk("pipe_in_data", 32'(data), 32'hFFFFFF);
    chk("pipe_in_de", 32'(de_out), 32'd1);
    de = 1'b0;
    tick();
    chk("pipe_edge_data", 32'(data), 32'h000000);
    chk("pipe_edge_de", 32'(de_out), 32'd1);
    tick();
    chk("pipe_idle_de", 32'(de_out), 32'd0);
    chk("pipe_idle_data", 32'(data), 32'h000000);
    pix("m0_field1", 35, 6, 1'b0, 1'b0, 24'hFFFFFF);
    pix("m0_outside", 25, 6, 1'b0, 1'b0, 24'h000000);
    pix("m0_degenerate", 50, 6, 1'b0, 1'b0, 24'h000000);
    pix("m0_ymax", 15, 8, 1'b0, 1'b0, 24'h000000);
    pix("m0_ovl_in_lit", 15, 6, 1'b1, 1'b1, 24'hFFFFFF);
    pix("m0_ovl0_in_lit", 15, 6, 1'b1, 1'b0, 24'hFFFFFF);
    set_rect(2, 50, 60, 5, 8);

    // reset while lit and streaming
    pos_x = 12'd15; pos_y = 12'd6; de = 1'b1;
    tick();
    tick();
    chk("stream_lit", 32'(data), 32'hFFFFFF);
    resetn = 1'b0;
    tick();
    chk("mrst_trig", 32'(starttrigger), 32'd0);
    chk("mrst_disp", 32'(display_on), 32'd0);
    chk("mrst_sel", 32'(field_sel), 32'd0);
    chk("mrst_de_out", 32'(de_out), 32'd0);
    chk("mrst_data", 32'(data), 32'd0);
    resetn = 1'b1;
    tick();
    chk("flush_de_out", 32'(de_out), 32'd0);
    chk("flush_data", 32'(data), 32'd0);
    tick();
    chk("post_rst_de_out", 32'(de_out), 32'd1);
    chk("post_rst_data", 32'(data), 32'd0);
    de = 1'b0;

    // mode 1 rotation, overlay passthrough, dark-phase overlay
    mode = 2'd1;
    run14(1'b1);

    // enable low mid-cycle: counters hold, display forced off
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fevent();
      chk($sformatf("dis_trig_%0d", i), 32'(starttrigger), 32'd0);
      chk($sformatf("dis_disp_%0d", i), 32'(display_on), 32'd0);
    end
    enable = 1'b1;
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      fevent();
      chk($sformatf("resume_trig_%0d", i), 32'(starttrigger), 32'd0);
      chk($sformatf("resume_disp_%0d", i), 32'(display_on), 32'd0);
    end
    fevent();
    chk("resume_trig_start", 32'(starttrigger), 32'd1);
    chk("resume_disp_start", 32'(display_on), 32'd1);
    chk("m2_field_sel", 32'(field_sel), 32'd0);
    pix("m2_full_area", 100, 100, 1'b0, 1'b0, 24'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flash_field_gen.md
# flash_field_gen

Parametrised flash-field and overlay pixel generator for the lag-measurement video path; successor to the single-mode field generator. Sits between the video timing generator and the TMDS/output encoder. Counts frames with a rotating jitter offset, flashes `NUM_FIELDS` programmable rectangles in one of three modes, and emits the measurement start trigger. Caller-supplied overlay bits (resolution/lag text) are composited at lower priority, and pixel data is delivered through a fixed 2-cycle pipeline.

## Interface
- `NUM_FIELDS`, 3: number of flash rectangles (1..8).
- `PERIOD`, 30: base frames per flash cycle (≥ `ON_FRAMES`+1).
- `ON_FRAMES`, 5: frames the fields stay lit per cycle (≥1).
- `JITTER_BITS`, 3: width of rotating period offset; 0 disables jitter.
- `DATA_WIDTH`, 24: pixel width.
- `FIELD_COLOR`, all ones: lit-field / overlay-on colour.
- `clock  in  1`: pixel clock, all logic rising-edge.
- `resetn  in  1`: synchronous, active-low reset.
- `enable  in  1`: run frame counter; low freezes it.
- `mode  in  2`: 0 = all fields together, 1 = sequential (one field per cycle), 2 = full active area, 3 = same as 0.
- `frame_start  in  1`: one-cycle pulse per frame from the timing generator.
- `de  in  1`: active-video qualifier for `pos_x`/`pos_y`.
- `pos_x`, `pos_y  in  12 each`: visible-area pixel coordinates.
- `field_rects  in  48*NUM_FIELDS`: per field k, bits [48k+47:48k] = {x_start, x_end, y_start, y_end}, 12 bits each; half-open ranges.
- `overlay_valid  in  1`: pixel lies inside a caller overlay region.
- `overlay_bit  in  1`: overlay pixel value.
- `starttrigger  out  1`: one-cycle pulse at the start of each flash cycle.
- `display_on  out  1`: fields currently lit.
- `field_sel  out  3`: field lit in mode 1 (0 otherwise).
- `de_out  out  1`: `de` delayed 2 cycles.
- `data  out  DATA_WIDTH`: pixel, aligned with `de_out`.

## Operation
- Registers: `frame_cnt` (wide enough for `PERIOD`+2^`JITTER_BITS`), `jitter` (`JITTER_BITS`), `burst` (3 bits, mod `NUM_FIELDS`), `mode_q`, `display_on`.
- Frame event = `frame_start` && `enable`. All counter updates use pre-event values:
  - `frame_cnt` <= (`frame_cnt` < `PERIOD`-1+`jitter`) ? `frame_cnt`+1 : 0.
  - `jitter` <= `jitter`+1, wraps modulo 2^`JITTER_BITS`.
  - if `frame_cnt`==0: `starttrigger`<=1, `display_on`<=1, `mode_q`<=`mode`; `burst` <= `burst`+1 mod `NUM_FIELDS`, except on the first cycle after reset (burst stays 0).
  - else if `frame_cnt` > `ON_FRAMES`-1: `display_on`<=0.
- `starttrigger` is 0 in every cycle without a qualifying event.
- `frame_start` with `enable` low: counters hold, `display_on`<=0, no trigger.
- `mode` is sampled only at cycle start (`frame_cnt`==0); mid-cycle changes take effect at the next cycle.
- Pixel priority, evaluated for `de`=1, else `data`=0:
  1. `display_on` and field hit -> `FIELD_COLOR`. Mode 0/3: any field k with x_start≤`pos_x`<x_end and y_start≤`pos_y`<y_end. Mode 1: only field `burst`. Mode 2: every active pixel.
  2. `overlay_valid` -> `overlay_bit` ? `FIELD_COLOR` : 0.
  3. Otherwise 0.
- Degenerate rectangle (end ≤ start on either axis) never hits.
- `field_sel` = `burst` when `mode_q`==1, otherwise 0.

## Timing
- Reset (`resetn`=0 at a clock edge): all counters, `mode_q`, `starttrigger`, `display_on`, `field_sel`, `de_out`, and `data` are 0 on the next cycle. The pipeline is flushed, so no stale pixels appear after release.
- `starttrigger`/`display_on` update 1 cycle after the qualifying `frame_start`.
- Pixel pipeline:
  - Stage 1 registers the per-field hit vector, the overlay decision, and `de`.
  - Stage 2 registers `data` and `de_out`.
  - Total latency is exactly 2 cycles from `pos_x`/`pos_y`/`de`/overlay inputs to `data`/`de_out`.
  - Throughput is 1 pixel/cycle with no stalls.
- `display_on` is sampled in stage 1. A change takes effect on the pixel presented in the same cycle the register updates.
- `frame_start` coinciding with `de`=1 is legal; the pixel path is independent.

## Test plan
- `PERIOD`=4, `ON_FRAMES`=2, `JITTER_BITS`=2, 14 `frame_start` pulses -> `starttrigger` on events 1, 6, 10, 14; `display_on` high from event 1 until event 3, and again from event 6 until event 8.
- Mode 0, field0 = {10,20,5,8}, `display_on` high, scan pixel (19,7) and (20,7) -> `data`=FFFFFF then 000000, each 2 cycles after input; `de_out` tracks `de`.
- Mode 1, `NUM_FIELDS`=3 -> `field_sel` 0,1,2,0 on successive cycles; only the selected rectangle lights; other rectangles pass the overlay.
- Overlay pixel (`overlay_valid`=1, `overlay_bit`=1) inside a lit field -> FFFFFF. With `display_on` low -> FFFFFF. With `overlay_bit`=0 and `display_on` low -> 0.
- `enable` low for 3 `frame_start`s mid-cycle -> `frame_cnt`/`jitter` unchanged, `display_on`=0, no trigger; re-enable resumes the count from the held value.
- `resetn` low for 1 cycle while `display_on`=1 and streaming `de`=1 -> next cycle all outputs 0; first trigger on the next `frame_start` after release.
